// File: rtl/deit_pkg.sv
// Shared sizing and controller state encoding for the DeiT compute core.
package deit_pkg;

  localparam int ARRAY_ROW  = 12;
  localparam int ARRAY_COL  = 16;
  localparam int DATA_WIDTH = 8;
  localparam int ACC_WIDTH  = 32;
  localparam int ACC_DEPTH  = 256;

  localparam int DRAIN_CYCLES = ARRAY_ROW + ARRAY_COL + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_COMPUTE,
    S_DRAIN,
    S_DONE
  } state_t;

endpackage

// File: rtl/deit_pe.sv
// One weight-stationary MAC cell: activation passes right, partial sum passes down.
module deit_pe
  import deit_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         w_load,
  input  logic signed [DATA_WIDTH-1:0] w_in,
  input  logic signed [DATA_WIDTH-1:0] act_in,
  input  logic signed [ACC_WIDTH-1:0]  psum_in,
  output logic signed [DATA_WIDTH-1:0] act_out,
  output logic signed [ACC_WIDTH-1:0]  psum_out
);

  logic signed [DATA_WIDTH-1:0]   w_q;
  logic signed [2*DATA_WIDTH-1:0] prod;

  assign prod = act_in * w_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      w_q      <= '0;
      act_out  <= '0;
      psum_out <= '0;
    end else begin
      if (w_load) w_q <= w_in;
      act_out  <= act_in;
      psum_out <= psum_in + {{(ACC_WIDTH-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
    end
  end

endmodule

// File: rtl/deit_core.sv
// DeiT compute core: start/done controller, INT8 weight-stationary systolic array, accumulator buffer.
// Define DEIT_ACC_SAT_EN to saturate accumulator writes instead of two's-complement wrap.
module deit_core
  import deit_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            ap_start,
  input  logic [31:0]                     cfg_compute_cycles,
  input  logic                            cfg_acc_mode,
  output logic                            ap_done,
  output logic                            ap_idle,
  input  logic [ARRAY_ROW*DATA_WIDTH-1:0] in_act_vec,
  input  logic [ARRAY_COL*DATA_WIDTH-1:0] in_weight_vec,
  output logic [ARRAY_COL*ACC_WIDTH-1:0]  out_acc_vec,
  output logic                            ctrl_weight_load_en,
  output logic                            ctrl_input_stream_en
);

  localparam int ROW_W   = $clog2(ARRAY_ROW);
  localparam int ADDR_W  = $clog2(ACC_DEPTH);
  localparam int VLD_LEN = ARRAY_ROW + ARRAY_COL - 1;

  function automatic logic signed [ACC_WIDTH-1:0] acc_sum(
    input logic signed [ACC_WIDTH-1:0] a,
    input logic signed [ACC_WIDTH-1:0] b
  );
`ifdef DEIT_ACC_SAT_EN
    logic signed [ACC_WIDTH:0] s;
    s = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
    if (s[ACC_WIDTH] != s[ACC_WIDTH-1])
      return s[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    return s[ACC_WIDTH-1:0];
`else
    return a + b;
`endif
  endfunction

  state_t      state, state_nx;
  logic [31:0] cnt, n_q;
  logic        mode_q;
  logic        start;

  assign start = (state == S_IDLE) && ap_start;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      n_q    <= '0;
      mode_q <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= (state_nx != state) ? '0 : cnt + 32'd1;
      if (start) begin
        n_q    <= cfg_compute_cycles;
        mode_q <= cfg_acc_mode;
      end
    end
  end

  always_comb begin
    state_nx             = state;
    ap_done              = 1'b0;
    ap_idle              = 1'b0;
    ctrl_weight_load_en  = 1'b0;
    ctrl_input_stream_en = 1'b0;
    case (state)
      S_IDLE: begin
        ap_idle = 1'b1;
        if (ap_start) state_nx = S_LOAD_W;
      end
      S_LOAD_W: begin
        ctrl_weight_load_en = 1'b1;
        if (cnt == 32'(ARRAY_ROW - 1)) state_nx = (n_q == '0) ? S_DONE : S_COMPUTE;
      end
      S_COMPUTE: begin
        ctrl_input_stream_en = 1'b1;
        if (cnt == n_q - 32'd1) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        if (cnt == 32'(DRAIN_CYCLES - 1)) state_nx = S_DONE;
      end
      S_DONE: begin
        ap_done  = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // p0: request strobes delayed into the buffer data cycle; p1: sampled activations
  logic                         w_vld_p0;
  logic [ROW_W-1:0]             w_row_p0;
  logic                         vld_p0, vld_p1;
  logic signed [DATA_WIDTH-1:0] act_p1 [ARRAY_ROW];

  always_ff @(posedge clk) begin
    if (rst) begin
      w_vld_p0 <= 1'b0;
      w_row_p0 <= '0;
      vld_p0   <= 1'b0;
      vld_p1   <= 1'b0;
      for (int r = 0; r < ARRAY_ROW; r++) act_p1[r] <= '0;
    end else begin
      w_vld_p0 <= ctrl_weight_load_en;
      w_row_p0 <= ROW_W'(cnt);
      vld_p0   <= ctrl_input_stream_en;
      vld_p1   <= vld_p0;
      for (int r = 0; r < ARRAY_ROW; r++)
        act_p1[r] <= vld_p0 ? $signed(in_act_vec[r*DATA_WIDTH +: DATA_WIDTH]) : '0;
    end
  end

  // Input skew: lane r enters the array r cycles late
  logic signed [DATA_WIDTH-1:0] row_in [ARRAY_ROW];

  for (genvar r = 0; r < ARRAY_ROW; r++) begin : g_skew
    if (r == 0) begin : g_direct
      assign row_in[r] = act_p1[r];
    end else begin : g_dly
      logic signed [DATA_WIDTH-1:0] dly [r];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < r; i++) dly[i] <= '0;
        end else begin
          dly[0] <= act_p1[r];
          for (int i = 1; i < r; i++) dly[i] <= dly[i-1];
        end
      end
      assign row_in[r] = dly[r-1];
    end
  end

  logic signed [DATA_WIDTH-1:0] pe_act  [ARRAY_ROW][ARRAY_COL];
  logic signed [ACC_WIDTH-1:0]  pe_psum [ARRAY_ROW][ARRAY_COL];

  for (genvar r = 0; r < ARRAY_ROW; r++) begin : g_row
    for (genvar c = 0; c < ARRAY_COL; c++) begin : g_col
      logic signed [DATA_WIDTH-1:0] a_in;
      logic signed [ACC_WIDTH-1:0]  p_in;
      if (c == 0) begin : g_a_edge
        assign a_in = row_in[r];
      end else begin : g_a_mid
        assign a_in = pe_act[r][c-1];
      end
      if (r == 0) begin : g_p_edge
        assign p_in = '0;
      end else begin : g_p_mid
        assign p_in = pe_psum[r-1][c];
      end
      deit_pe u_pe (
        .clk      (clk),
        .rst      (rst),
        .w_load   (w_vld_p0 && (w_row_p0 == ROW_W'(r))),
        .w_in     ($signed(in_weight_vec[c*DATA_WIDTH +: DATA_WIDTH])),
        .act_in   (a_in),
        .psum_in  (p_in),
        .act_out  (pe_act[r][c]),
        .psum_out (pe_psum[r][c])
      );
    end
  end

  // Output deskew: column c waits ARRAY_COL-1-c cycles so one vector lines up
  logic signed [ACC_WIDTH-1:0] col_al [ARRAY_COL];

  for (genvar c = 0; c < ARRAY_COL; c++) begin : g_deskew
    localparam int D = ARRAY_COL - 1 - c;
    if (D == 0) begin : g_direct
      assign col_al[c] = pe_psum[ARRAY_ROW-1][c];
    end else begin : g_dly
      logic signed [ACC_WIDTH-1:0] dly [D];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < D; i++) dly[i] <= '0;
        end else begin
          dly[0] <= pe_psum[ARRAY_ROW-1][c];
          for (int i = 1; i < D; i++) dly[i] <= dly[i-1];
        end
      end
      assign col_al[c] = dly[D-1];
    end
  end

  // Write stage: valid follows the sampled vector through array and deskew
  logic [VLD_LEN-1:0]             vld_pipe;
  logic                           wr_en;
  logic [ADDR_W-1:0]              wr_addr;
  logic [ARRAY_COL*ACC_WIDTH-1:0] acc_mem [ACC_DEPTH];
  logic [ARRAY_COL*ACC_WIDTH-1:0] acc_old, wr_data;

  assign wr_en   = vld_pipe[VLD_LEN-1] && !rst;
  assign acc_old = acc_mem[wr_addr];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      wr_addr  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[VLD_LEN-2:0], vld_p1};
      if (start) wr_addr <= '0;
      else if (wr_en) wr_addr <= wr_addr + ADDR_W'(1);
    end
  end

  always_comb begin
    wr_data = '0;
    for (int c = 0; c < ARRAY_COL; c++)
      wr_data[c*ACC_WIDTH +: ACC_WIDTH] =
        acc_sum(mode_q ? $signed(acc_old[c*ACC_WIDTH +: ACC_WIDTH]) : '0, col_al[c]);
  end

  always_ff @(posedge clk) begin
    if (wr_en) acc_mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) out_acc_vec <= '0;
    else if (wr_en) out_acc_vec <= wr_data;
  end

endmodule

// File: tb/tb_deit_core.sv
// Directed bench for deit_core with a job-level reference model checked every cycle.
module tb_deit_core;
  import deit_pkg::*;

  localparam int R      = ARRAY_ROW;
  localparam int C      = ARRAY_COL;
  localparam int WR_REL = R + 2 + R + C;
  localparam int NACT   = 64;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     ap_start = 1'b0;
  logic [31:0]              cfg_compute_cycles = '0;
  logic                     cfg_acc_mode = 1'b0;
  logic                     ap_done, ap_idle;
  logic [R*DATA_WIDTH-1:0]  in_act_vec = '0;
  logic [C*DATA_WIDTH-1:0]  in_weight_vec = '0;
  logic [C*ACC_WIDTH-1:0]   out_acc_vec;
  logic                     ctrl_weight_load_en, ctrl_input_stream_en;

  always #5 clk = ~clk;

  deit_core dut (
    .clk                  (clk),
    .rst                  (rst),
    .ap_start             (ap_start),
    .cfg_compute_cycles   (cfg_compute_cycles),
    .cfg_acc_mode         (cfg_acc_mode),
    .ap_done              (ap_done),
    .ap_idle              (ap_idle),
    .in_act_vec           (in_act_vec),
    .in_weight_vec        (in_weight_vec),
    .out_acc_vec          (out_acc_vec),
    .ctrl_weight_load_en  (ctrl_weight_load_en),
    .ctrl_input_stream_en (ctrl_input_stream_en)
  );

  int w_tb   [R][C];
  int act_tb [NACT][R];
  int mem_m  [ACC_DEPTH][C];
  logic [C*ACC_WIDTH-1:0] exp_vec = '0;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  int ecnt = 0, t0 = 0, jn = 0;
  bit jm = 1'b0, active = 1'b0;

  task automatic chk(input string name, input longint got, input longint want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s t=%0t got=%0d want=%0d", name, $time, got, want);
    end
  endtask

  task automatic chk_vec(input string name, input logic [C*ACC_WIDTH-1:0] want);
    total++;
    if (out_acc_vec !== want) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, out_acc_vec, want);
    end
  endtask

  function automatic logic [C*ACC_WIDTH-1:0] fill(input int v);
    logic [C*ACC_WIDTH-1:0] x;
    for (int c = 0; c < C; c++) x[c*ACC_WIDTH +: ACC_WIDTH] = v;
    return x;
  endfunction

  function automatic int job_dur(input int n);
    return (n == 0) ? R : R + n + R + C + 1;
  endfunction

  task automatic model_write(input int k);
    for (int c = 0; c < C; c++) begin
      longint s;
      int     v;
      s = 0;
      for (int r = 0; r < R; r++) s += longint'(act_tb[k % NACT][r]) * longint'(w_tb[r][c]);
      if (jm) s += longint'(mem_m[k % ACC_DEPTH][c]);
`ifdef DEIT_ACC_SAT_EN
      if (s > 64'sd2147483647) s = 64'sd2147483647;
      else if (s < -64'sd2147483648) s = -64'sd2147483648;
`endif
      v = int'(s);
      mem_m[k % ACC_DEPTH][c] = v;
      exp_vec[c*ACC_WIDTH +: ACC_WIDTH] = v;
    end
  endtask

  // Job-level model: timeline derived from the start edge, N and mode
  always @(posedge clk) begin
    int rel;
    ecnt++;
    if (rst) begin
      active  = 1'b0;
      exp_vec = '0;
    end else if (!active) begin
      if (ap_start) begin
        active = 1'b1;
        t0     = ecnt;
        jn     = int'(cfg_compute_cycles);
        jm     = cfg_acc_mode;
      end
    end else begin
      rel = ecnt - t0;
      if (rel >= WR_REL && rel - WR_REL < jn) model_write(rel - WR_REL);
      if (rel == job_dur(jn) + 1) active = 1'b0;
    end
  end

  always @(negedge clk) begin
    int rel;
    if (chk_on) begin
      rel = ecnt - t0;
      chk("ap_idle", ap_idle, !active);
      chk("ap_done", ap_done, active && rel == job_dur(jn));
      chk("weight_load_en", ctrl_weight_load_en, active && rel < R);
      chk("input_stream_en", ctrl_input_stream_en, active && rel >= R && rel < R + jn);
      chk_vec("out_acc_vec", exp_vec);
    end
  end

  // External buffers: answer each request one cycle later, garbage otherwise
  initial begin
    int wi, ai;
    bit wl, se;
    wi = 0;
    ai = 0;
    forever begin
      @(posedge clk);
      wl = ctrl_weight_load_en;
      se = ctrl_input_stream_en;
      if (ap_start && ap_idle && !rst) begin
        wi = 0;
        ai = 0;
      end
      #1;
      for (int c = 0; c < C; c++)
        in_weight_vec[c*DATA_WIDTH +: DATA_WIDTH] = wl ? DATA_WIDTH'(w_tb[wi % R][c]) : DATA_WIDTH'($urandom());
      for (int r = 0; r < R; r++)
        in_act_vec[r*DATA_WIDTH +: DATA_WIDTH] = se ? DATA_WIDTH'(act_tb[ai % NACT][r]) : DATA_WIDTH'($urandom());
      if (wl) wi++;
      if (se) ai++;
    end
  end

  task automatic set_data(input int wsel, input int asel);
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        w_tb[r][c] = (wsel == 0) ? 1 : (wsel == 1) ? r + 1 : -128;
    for (int k = 0; k < NACT; k++)
      for (int r = 0; r < R; r++)
        act_tb[k][r] = (asel == 0) ? 1 : (asel == 1) ? k : 127;
  endtask

  task automatic run_job(input string name, input int n, input bit mode,
                         input int want_lat, input int poke);
    int lat;
    @(negedge clk);
    cfg_compute_cycles = n;
    cfg_acc_mode       = mode;
    ap_start           = 1'b1;
    @(negedge clk);
    ap_start           = 1'b0;
    cfg_compute_cycles = 32'd999;
    cfg_acc_mode       = ~mode;
    lat = 0;
    while (!ap_done && lat < 3000) begin
      ap_start = (lat == poke);
      if (lat == poke) begin
        cfg_compute_cycles = 32'd3;
        cfg_acc_mode       = 1'b1;
      end
      @(negedge clk);
      lat++;
    end
    ap_start = 1'b0;
    chk({name, "_done_latency"}, lat, want_lat);
    @(negedge clk);
    chk({name, "_idle_after"}, ap_idle, 1);
  endtask

  initial begin
    int dcnt;
    set_data(0, 0);
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    chk("reset_idle", ap_idle, 1);
    chk("reset_done", ap_done, 0);
    chk_vec("reset_out", fill(0));
    rst = 1'b0;

    run_job("ones_ovr", 16, 1'b0, 57, -1);
    chk_vec("ones_ovr_out", fill(12));

    run_job("ones_acc", 16, 1'b1, 57, -1);
    chk_vec("ones_acc_out", fill(24));

    set_data(1, 1);
    run_job("ramp", 4, 1'b0, 45, -1);
    chk_vec("ramp_out", fill(234));

    set_data(2, 2);
    run_job("signed", 1, 1'b0, 42, -1);
    chk_vec("signed_out", fill(-195072));

    run_job("zero_n", 0, 1'b0, 12, -1);
    chk_vec("zero_n_hold", fill(-195072));

    set_data(1, 1);
    run_job("poke", 8, 1'b0, 49, 15);
    chk_vec("poke_out", fill(7 * 78));

    // Abort mid-COMPUTE with reset
    set_data(0, 0);
    @(negedge clk);
    cfg_compute_cycles = 32'd8;
    cfg_acc_mode       = 1'b0;
    ap_start           = 1'b1;
    @(negedge clk);
    ap_start = 1'b0;
    repeat (14) @(negedge clk);
    chk("abort_mid_compute", ctrl_input_stream_en, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_idle", ap_idle, 1);
    chk("abort_stream_en", ctrl_input_stream_en, 0);
    chk_vec("abort_out", fill(0));
    dcnt = 0;
    repeat (60) begin
      @(negedge clk);
      if (ap_done) dcnt++;
    end
    chk("abort_no_done", dcnt, 0);

    run_job("recover", 2, 1'b0, 43, -1);
    chk_vec("recover_out", fill(12));

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/deit_core.md
Name: deit_core

Overview:
Compute core of the DeiT accelerator. It contains a start/done controller, a weight-stationary systolic array of ARRAY_ROW x ARRAY_COL INT8 MACs, and a per-column accumulator buffer. The controller requests weight rows and activation vectors from the external buffers through enable strobes. Column results are written into the accumulator buffer, either overwriting or adding, and the last written vector is presented on out_acc_vec.

Parameters:
ARRAY_ROW, 12, array rows (dot-product length, activation lanes)
ARRAY_COL, 16, array columns (output lanes)
DATA_WIDTH, 8, signed activation/weight width
ACC_WIDTH, 32, signed accumulator width
ACC_DEPTH, 256, accumulator entries per column (power of 2)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
ap_start  in  1  start pulse; sampled only in IDLE
cfg_compute_cycles  in  32  N = number of activation vectors; latched at start
cfg_acc_mode  in  1  0 = overwrite, 1 = accumulate into buffer; latched at start
ap_done  out  1  one-cycle pulse at completion
ap_idle  out  1  high while in IDLE
in_act_vec  in  ARRAY_ROW*DATA_WIDTH  activation vector; lane r at bits [r*8 +: 8]
in_weight_vec  in  ARRAY_COL*DATA_WIDTH  weight row; lane c at bits [c*8 +: 8]
out_acc_vec  out  ARRAY_COL*ACC_WIDTH  last value written to the accumulator buffer; column c at [c*ACC_WIDTH +: ACC_WIDTH]
ctrl_weight_load_en  out  1  requests one weight row per cycle
ctrl_input_stream_en  out  1  requests one activation vector per cycle

Behaviour:
- Reset values: ap_idle=1, ap_done=0, both ctrl enables 0, out_acc_vec=0. Reset also clears array registers, skew registers and all counters. Accumulator RAM contents are not cleared.
- Reset asserted mid-operation aborts immediately to IDLE. No ap_done is generated.
- Buffer read latency is 1 cycle: the vector on in_*_vec is sampled in the cycle after the matching ctrl_*_en cycle.
- FSM states: IDLE, LOAD_W, COMPUTE, DRAIN, DONE.
- IDLE: on ap_start=1, latch N and mode, then go to LOAD_W. ap_start is ignored in every other state.
- LOAD_W: lasts ARRAY_ROW cycles with ctrl_weight_load_en=1. The k-th requested row, sampled one cycle later, is written to array row k (addressed write). Weights stay stationary until the next LOAD_W.
- COMPUTE: lasts N cycles with ctrl_input_stream_en=1, then go to DRAIN. If N=0, skip directly from LOAD_W to DONE with no writes.
- DRAIN: lasts ARRAY_ROW+ARRAY_COL+1 cycles with both enables 0, then go to DONE.
- DONE: ap_done=1 for one cycle, then go to IDLE.
- Datapath: activation lane r is skewed by r cycles and moves right through PEs. Partial sums move down the columns. Column outputs are deskewed so all lanes of one vector align.
- Result for vector k: result[k][c] = sum over r of act_k[r]*w[r][c], signed, sign-extended to ACC_WIDTH.
- Write timing: result[k] is written to address k mod ACC_DEPTH exactly ARRAY_ROW+ARRAY_COL cycles after act_k is sampled.
- Accumulator write rule: mode 0 stores result. Mode 1 stores old + result, using an asynchronous (LUTRAM) read of the same address. Sums wrap modulo 2^ACC_WIDTH.
- out_acc_vec is registered: it updates with the stored value in the write cycle and holds otherwise.
- Input data while both enables are low is ignored (bubbles are treated as zero).
- Timing: ap_done is high exactly ARRAY_ROW + N + ARRAY_ROW + ARRAY_COL + 1 cycles after the edge that sampled ap_start (57 with default parameters and N=16).

Optional Feature:
DEIT_ACC_SAT_EN
- Defined: each stored value and each accumulate sum saturates to the signed ACC_WIDTH range (0x7FFFFFFF / 0x80000000) instead of wrapping.
- Undefined: two's-complement wrap.

Decomposition:
- Package deit_pkg holds DATA_WIDTH, ACC_WIDTH, ARRAY_ROW, ARRAY_COL, ACC_DEPTH and the FSM state enum.
- Sub-module deit_pe implements one MAC cell: weight register, activation pass-right register, psum-in plus act*w register.
- deit_core holds the FSM, skew/deskew logic, PE generate array and accumulator RAM.

Test Plan:
- Reset, then ap_start with N=16, mode 0, all weights and activations = 1: exactly 12 weight-load cycles then 16 stream cycles; every column writes 12 to addresses 0..15; ap_done at +57 cycles; ap_idle returns to 1.
- Run the same job twice, second with mode 1: addresses 0..15 hold 24; out_acc_vec shows 24 per column.
- Weight row r = r+1, act_k[r] = k, N=4: result[k][c] = k*78.
- Signed values: weights -128, acts 127, N=1: each column = -195072.
- N=0: no stream cycles, no writes, ap_done 12 cycles after the start edge.
- ap_start pulse during COMPUTE is ignored. rst raised mid-COMPUTE gives the IDLE outputs next cycle with no ap_done.
